// File: rtl/rv32_pkg.sv
// Shared RV32I control definitions: opcodes, sequencer state encodings,
// datapath select codes and the per-cycle control bundle.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_LOAD  = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_RF   = 2'b10;
    localparam logic [1:0] ALU_IF   = 2'b11;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       retire;
    } ctrl_t;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: op_legal = 1'b1;
            default:                    op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts consecutive stalled cycles and flags the
// cycle in which the TIMEOUT-th stall is being spent. TIMEOUT=0 disables it.
module mc_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // cnt holds the number of stalls already spent, so it never needs to reach TIMEOUT
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes
// and a sticky trap. Define MC_PERF_CNT_EN to add cycle/instret counters.
module multicycle_ctrl
    import rv32_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       trap,
    output logic [2:0] state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    state_e state, state_nxt;
    ctrl_t  ctl, ctl_o;
    logic   wait_en, expired;
    logic   is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr;

    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign is_ld   = (opcode == OP_LOAD);
    assign is_st   = (opcode == OP_STORE);
    assign is_br   = (opcode == OP_BRANCH);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!wait_en),
        .en      (wait_en),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        ctl       = '0;
        wait_en   = 1'b0;
        case (state)
            S_FETCH: begin
                ctl.imem_req = 1'b1;
                if (imem_ack) begin
                    ctl.ir_we = 1'b1;
                    state_nxt = S_DECODE;
                end else begin
                    wait_en = 1'b1;
                    if (expired) state_nxt = S_TRAP;
                end
            end
            S_DECODE: state_nxt = op_legal(opcode) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                ctl.alu_src_b = !(is_r || is_br);
                ctl.alu_op    = is_r ? ALU_RF : is_i ? ALU_IF : is_br ? ALU_BR : ALU_ADD;
                if (is_br) begin
                    ctl.pc_we  = 1'b1;
                    ctl.pc_src = branch_taken ? PC_IMM : PC_PLUS4;
                    ctl.retire = 1'b1;
                    state_nxt  = S_FETCH;
                end else if (is_ld || is_st) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                ctl.dmem_req = 1'b1;
                ctl.dmem_we  = is_st;
                if (dmem_ack) begin
                    if (is_st) begin
                        ctl.pc_we  = 1'b1;
                        ctl.retire = 1'b1;
                        state_nxt  = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else begin
                    wait_en = 1'b1;
                    if (expired) state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                ctl.reg_we = 1'b1;
                ctl.pc_we  = 1'b1;
                ctl.retire = 1'b1;
                ctl.wb_sel = is_ld ? WB_LOAD : (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
                ctl.pc_src = is_jal ? PC_IMM : is_jalr ? PC_ALU : PC_PLUS4;
                state_nxt  = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_TRAP;
        endcase
    end

    // A reset cycle aborts whatever is in flight, so nothing may commit in it
    assign ctl_o = rst_n ? ctl : '0;

    assign imem_req  = ctl_o.imem_req;
    assign dmem_req  = ctl_o.dmem_req;
    assign dmem_we   = ctl_o.dmem_we;
    assign ir_we     = ctl_o.ir_we;
    assign pc_we     = ctl_o.pc_we;
    assign pc_src    = ctl_o.pc_src;
    assign alu_src_b = ctl_o.alu_src_b;
    assign alu_op    = ctl_o.alu_op;
    assign reg_we    = ctl_o.reg_we;
    assign wb_sel    = ctl_o.wb_sel;
    assign retire    = ctl_o.retire;
    assign trap      = (state == S_TRAP);
    assign state_o   = state;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (state != S_TRAP) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (ctl_o.retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule
